step_controller: RTL and testbench

- Run/halt/single-step sequencer directly upstream of the program counter stage.
- Generates the counter's one-cycle `enable` pulses at a programmable rate and a one-cycle `clear` pulse that drives the counter's reset input.
- Watches the counter value fed back via `count_in` and halts on a breakpoint match.
- Gives the debug/console logic start, stop and step control over the counter.

---
 rtl/step_controller_if.sv | 29 ++
 rtl/step_controller.sv | 147 ++++++++++++++
 tb/tb_step_controller.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/step_controller_if.sv
// Control and status bundle between the debug/console logic and step_controller.
// The controller takes the slave modport; whoever drives the controls takes master.
interface step_controller_if #(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 8
);
   logic                  start;
   logic                  stop;
   logic                  step;
   logic                  clear_req;
   logic [PRESCALE_W-1:0] prescale;
   logic [WIDTH-1:0]      count_in;
   logic [WIDTH-1:0]      bp_addr;
   logic                  bp_en;
   logic                  enable;
   logic                  clear;
   logic [1:0]            state;
   logic                  halted;

   modport master (
      output start, stop, step, clear_req, prescale, count_in, bp_addr, bp_en,
      input  enable, clear, state, halted
   );

   modport slave (
      input  start, stop, step, clear_req, prescale, count_in, bp_addr, bp_en,
      output enable, clear, state, halted
   );
endinterface

// File: rtl/step_controller.sv
// Run/halt/single-step sequencer feeding the program counter stage.
// Emits one-cycle enable pulses at a programmable rate and one-cycle clear
// pulses, and halts when the fed-back counter value hits a breakpoint.
//
// Optional macro STEP_CTRL_BREAKPOINT_EN: when defined, the breakpoint
// compare, the skip flag and the BREAK state are built. When undefined,
// bp_addr/bp_en are ignored and BREAK is never entered.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE 00 | halted, waiting for start/step; clear_req pulses clear
// RUN  01 | free running, one enable every prescale+1 cycles
// STEP 10 | single cycle; issues one enable then returns to IDLE
// BREAK 11| halted on breakpoint; start resumes past the matching address
module step_controller #(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 8
) (
   input logic              clock,
   input logic              reset,
   step_controller_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_STEP  = 2'b10,
      S_BREAK = 2'b11
   } state_t;

   state_t                state_q, state_n;
   logic                  enable_q, enable_n;
   logic                  clear_q, clear_n;
   logic [PRESCALE_W-1:0] pcnt_q, pcnt_n;
   logic                  bp_hit;

`ifdef STEP_CTRL_BREAKPOINT_EN
   logic skip_q, skip_n;

   // The registered enable is added so an increment still in flight is
   // compared against the value the counter is about to take.
   assign bp_hit = bus.bp_en && !skip_q &&
                   (bus.bp_addr == WIDTH'(bus.count_in + WIDTH'(enable_q)));
`else
   logic unused_bp;

   assign unused_bp = ^{bus.bp_addr, bus.bp_en};
   assign bp_hit    = 1'b0;
`endif

   // State, output pulses and prescale counter registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         enable_q <= 1'b0;
         clear_q  <= 1'b0;
         pcnt_q   <= '0;
`ifdef STEP_CTRL_BREAKPOINT_EN
         skip_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_n;
         enable_q <= enable_n;
         clear_q  <= clear_n;
         pcnt_q   <= pcnt_n;
`ifdef STEP_CTRL_BREAKPOINT_EN
         skip_q   <= skip_n;
`endif
      end
   end

   // Next state and next pulses; priority clear_req > stop > step > start.
   always_comb begin
      state_n  = state_q;
      enable_n = 1'b0;
      clear_n  = 1'b0;
      pcnt_n   = pcnt_q;
`ifdef STEP_CTRL_BREAKPOINT_EN
      skip_n   = skip_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.clear_req) begin
               clear_n = 1'b1;
            end else if (!bus.stop) begin
               if (bus.step) begin
                  state_n = S_STEP;
               end else if (bus.start) begin
                  state_n = S_RUN;
                  pcnt_n  = '0;
`ifdef STEP_CTRL_BREAKPOINT_EN
                  skip_n  = 1'b0;
`endif
               end
            end
         end
         S_RUN: begin
            if (bus.clear_req) begin
               clear_n = 1'b1;
               state_n = S_IDLE;
            end else if (bus.stop) begin
               state_n = S_IDLE;
            end else if (pcnt_q == bus.prescale) begin
               pcnt_n = '0;
               if (bp_hit) begin
                  state_n = S_BREAK;
               end else begin
                  enable_n = 1'b1;
`ifdef STEP_CTRL_BREAKPOINT_EN
                  skip_n   = 1'b0;
`endif
               end
            end else begin
               // A prescale lowered below pcnt lets pcnt wrap through zero.
               pcnt_n = pcnt_q + PRESCALE_W'(1);
            end
         end
         S_STEP: begin
            enable_n = 1'b1;
            state_n  = S_IDLE;
         end
         S_BREAK: begin
            if (bus.clear_req) begin
               clear_n = 1'b1;
               state_n = S_IDLE;
            end else if (bus.stop) begin
               state_n = S_IDLE;
            end else if (bus.step) begin
               state_n = S_STEP;
            end else if (bus.start) begin
               state_n = S_RUN;
               pcnt_n  = '0;
`ifdef STEP_CTRL_BREAKPOINT_EN
               skip_n  = 1'b1;
`endif
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign bus.enable = enable_q;
   assign bus.clear  = clear_q;
   assign bus.state  = state_q;
   assign bus.halted = (state_q == S_IDLE) || (state_q == S_BREAK);

endmodule

// File: tb/tb_step_controller.sv
// Bench for step_controller: a behavioural counter downstream of the
// controller, a cycle model of the expected outputs, and directed scenarios.
module tb_step_controller;
   localparam int WIDTH = 8;
   localparam int PW    = 8;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_STEP = 2;
   localparam int M_BRK  = 3;

   logic clock = 1'b0;
   logic reset = 1'b0;

   step_controller_if #(.WIDTH(WIDTH), .PRESCALE_W(PW)) bus ();

   step_controller #(.WIDTH(WIDTH), .PRESCALE_W(PW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Program counter stage: not touched by reset, only by clear.
   logic [WIDTH-1:0] counter = '0;
   always @(posedge clock) begin
      if (bus.clear)       counter <= '0;
      else if (bus.enable) counter <= counter + 8'd1;
   end
   assign bus.count_in = counter;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: mode, cycles left before the next rate tick,
   // pending output pulses and the counter value they produce.
   int               m_state = M_IDLE;
   int               m_wait  = 0;
   bit               m_skip  = 1'b0;
   bit               m_en    = 1'b0;
   bit               m_clr   = 1'b0;
   logic [WIDTH-1:0] m_count = '0;

   always @(posedge clock or posedge reset) begin : model
      logic [WIDTH-1:0] nc;
      int               ns;
      bit               ne, ncl, hit;
      if (reset) begin
         m_state = M_IDLE;
         m_en    = 1'b0;
         m_clr   = 1'b0;
         m_wait  = 0;
         m_skip  = 1'b0;
      end else begin
         nc  = m_clr ? 8'd0 : (m_en ? m_count + 8'd1 : m_count);
         hit = 1'b0;
`ifdef STEP_CTRL_BREAKPOINT_EN
         hit = bus.bp_en && !m_skip && (bus.bp_addr == 8'(m_count + 8'(m_en)));
`endif
         ns  = m_state;
         ne  = 1'b0;
         ncl = 1'b0;
         case (m_state)
            M_IDLE: begin
               if (bus.clear_req) ncl = 1'b1;
               else if (bus.stop) ns = M_IDLE;
               else if (bus.step) ns = M_STEP;
               else if (bus.start) begin
                  ns = M_RUN; m_wait = int'(bus.prescale); m_skip = 1'b0;
               end
            end
            M_RUN: begin
               if (bus.clear_req) begin ncl = 1'b1; ns = M_IDLE; end
               else if (bus.stop) ns = M_IDLE;
               else if (m_wait == 0) begin
                  m_wait = int'(bus.prescale);
                  if (hit) ns = M_BRK;
                  else begin ne = 1'b1; m_skip = 1'b0; end
               end else m_wait = m_wait - 1;
            end
            M_STEP: begin ne = 1'b1; ns = M_IDLE; end
            default: begin
               if (bus.clear_req) begin ncl = 1'b1; ns = M_IDLE; end
               else if (bus.stop) ns = M_IDLE;
               else if (bus.step) ns = M_STEP;
               else if (bus.start) begin
                  ns = M_RUN; m_wait = int'(bus.prescale); m_skip = 1'b1;
               end
            end
         endcase
         m_count = nc;
         m_en    = ne;
         m_clr   = ncl;
         m_state = ns;
      end
   end

   bit cmp_on = 1'b0;

   // Every cycle, away from the active edge, outputs must match the model.
   always @(negedge clock) begin
      if (cmp_on) begin
         check("enable", int'(bus.enable), int'(m_en));
         check("clear", int'(bus.clear), int'(m_clr));
         check("state", int'(bus.state), m_state);
         check("halted", int'(bus.halted), int'(m_state == M_IDLE || m_state == M_BRK));
         check("count", int'(counter), int'(m_count));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic pulse_start();
      bus.start = 1'b1; @(negedge clock); bus.start = 1'b0;
   endtask
   task automatic pulse_stop();
      bus.stop = 1'b1; @(negedge clock); bus.stop = 1'b0;
   endtask
   task automatic pulse_step();
      bus.step = 1'b1; @(negedge clock); bus.step = 1'b0;
   endtask
   task automatic pulse_clear();
      bus.clear_req = 1'b1; @(negedge clock); bus.clear_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ens;
      int base;
      int waited;
      logic [WIDTH-1:0] held;

      bus.start = 1'b0; bus.stop = 1'b0; bus.step = 1'b0; bus.clear_req = 1'b0;
      bus.prescale = '0; bus.bp_addr = '0; bus.bp_en = 1'b0;
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      cmp_on = 1'b1;

      // Reset state, then idle.
      check("rst_state", int'(bus.state), 0);
      check("rst_halted", int'(bus.halted), 1);
      check("rst_enable", int'(bus.enable), 0);
      check("rst_clear", int'(bus.clear), 0);
      tick(10);
      check("idle_state", int'(bus.state), 0);

      // prescale=3: enables on cycles 4, 8, 12, 16, 20 after the start edge.
      bus.prescale = 8'd3;
      pulse_start();
      ens = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clock);
         check($sformatf("rate_c%0d", k), int'(bus.enable), int'(k % 4 == 0));
         if (bus.enable) ens++;
         if (k == 10) check("run_halted", int'(bus.halted), 0);
      end
      check("rate_pulses", ens, 5);
      check("rate_count_c20", int'(counter), 4);
      pulse_stop();
      check("rate_count_final", int'(counter), 5);
      check("stop_state", int'(bus.state), 0);
      pulse_clear();
      tick(1);
      check("cleared", int'(counter), 0);

      // Breakpoint at 6 with continuous enables.
      bus.prescale = 8'd0;
      bus.bp_addr  = 8'd6;
      bus.bp_en    = 1'b1;
      pulse_start();
      tick(10);
`ifdef STEP_CTRL_BREAKPOINT_EN
      check("bp_count", int'(counter), 6);
      check("bp_state", int'(bus.state), 3);
      check("bp_halted", int'(bus.halted), 1);
      pulse_start();
      tick(3);
      check("resume_count", int'(counter), 8);
      check("resume_state", int'(bus.state), 1);
`else
      check("nobp_count", int'(counter), 9);
      check("nobp_state", int'(bus.state), 1);
`endif
      pulse_stop();
      bus.bp_en = 1'b0;
      pulse_clear();
      tick(2);
      check("cleared2", int'(counter), 0);

      // Two single steps, three cycles apart.
      base = int'(counter);
      ens  = 0;
      pulse_step();
      check("step1_state", int'(bus.state), 2);
      tick(1);
      check("step1_enable", int'(bus.enable), 1);
      check("step1_idle", int'(bus.state), 0);
      ens += int'(bus.enable);
      tick(1);
      pulse_step();
      check("step2_state", int'(bus.state), 2);
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         ens += int'(bus.enable);
      end
      check("step_pulses", ens, 2);
      check("step_count", int'(counter), base + 2);
      check("step_idle", int'(bus.state), 0);

      // clear_req and stop together during RUN.
      bus.prescale = 8'd1;
      pulse_start();
      tick(4);
      bus.clear_req = 1'b1;
      bus.stop      = 1'b1;
      @(negedge clock);
      bus.clear_req = 1'b0;
      bus.stop      = 1'b0;
      check("cs_clear", int'(bus.clear), 1);
      check("cs_enable", int'(bus.enable), 0);
      check("cs_state", int'(bus.state), 0);
      tick(1);
      check("cs_count", int'(counter), 0);
      check("cs_clear_done", int'(bus.clear), 0);

      // Async reset mid-RUN while enable is high.
      bus.prescale = 8'd0;
`ifdef STEP_CTRL_BREAKPOINT_EN
      bus.bp_en = 1'b0;
`else
      bus.bp_en   = 1'b1;
      bus.bp_addr = 8'd2;
`endif
      pulse_start();
      waited = 0;
      while (!bus.enable && waited < 20) begin
         @(negedge clock);
         waited++;
      end
      check("wait_enable", int'(bus.enable), 1);
      tick(4);
      check("past_bp_state", int'(bus.state), 1);
      check("past_bp_count", int'(counter > 8'd2), 1);
      check("pre_reset_enable", int'(bus.enable), 1);
      held = counter;
      #2 reset = 1'b1;
      #1;
      check("async_enable", int'(bus.enable), 0);
      check("async_state", int'(bus.state), 0);
      check("async_halted", int'(bus.halted), 1);
      @(negedge clock);
      reset = 1'b0;
      check("reset_count_kept", int'(counter), int'(held));
      tick(3);
      check("post_reset_state", int'(bus.state), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
